// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin front end that shares one iterative square-root
// engine between two requesters. Only one operation is in flight at a time.
// A watchdog aborts an operation whose engine never reports a result.

module sqrt_arbiter #(
  parameter int TIMEOUT_CYC  = 255,
  parameter int DEFAULT_ITER = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [31:0] req_din0,
  input  logic [31:0] req_din1,
  input  logic [4:0]  req_iter0,
  input  logic [4:0]  req_iter1,
  output logic [1:0]  req_ack,
  output logic        res_valid,
  output logic        res_id,
  output logic [15:0] res_dout,
  output logic        res_timeout,
  output logic        eng_start,
  output logic        eng_vldin,
  output logic [31:0] eng_din,
  output logic [4:0]  eng_iter,
  input  logic [15:0] eng_dout,
  input  logic        eng_ready,
  input  logic        eng_busy
);

  // Timer counts WAIT cycles; it expires on the last allowed WAIT cycle so
  // that WAIT lasts at most TIMEOUT_CYC cycles.
  localparam int TMR_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int TMR_LAST_I = (TIMEOUT_CYC > 1) ? (TIMEOUT_CYC - 1) : 0;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TMR_LAST_I);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [4:0]       DEF_ITER = DEFAULT_ITER[4:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // A request with iter=0 asks for the default iteration count.
  function automatic logic [4:0] eff_iter(input logic [4:0] iter);
    return (iter == 5'd0) ? DEF_ITER : iter;
  endfunction

  // Ack pattern for the chosen requester.
  function automatic logic [1:0] ack_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

  state_t            state_r, state_s;
  logic              last_r, last_s;       // requester granted most recently
  logic              lat_id_r, lat_id_s;   // owner of the in-flight operation
  logic [TMR_W-1:0]  timer_r, timer_s;
  logic [1:0]        req_ack_r, req_ack_s;
  logic              res_valid_r, res_valid_s;
  logic              res_id_r, res_id_s;
  logic [15:0]       res_dout_r, res_dout_s;
  logic              res_timeout_r, res_timeout_s;
  logic              eng_start_r, eng_start_s;
  logic [31:0]       eng_din_r, eng_din_s;
  logic [4:0]        eng_iter_r, eng_iter_s;

  logic              grant_id_s;
  logic              take_s;
  logic              hit_s;
  logic              expire_s;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    grant_id_s = 1'b0;
    if (req_valid == 2'b11) begin
      grant_id_s = ~last_r;
    end else if (req_valid == 2'b10) begin
      grant_id_s = 1'b1;
    end else begin
      grant_id_s = 1'b0;
    end
  end

  // FSM events: accept a request, engine result, watchdog expiry.
  // A result arriving on the expiry cycle wins over the timeout.
  always_comb begin
    take_s   = (state_r == IDLE) && (req_valid != 2'b00) && !eng_busy;
    hit_s    = (state_r == WAIT) && eng_ready;
    expire_s = (state_r == WAIT) && !eng_ready && (timer_r == TMR_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        state_s = WAIT;
      end
      WAIT: begin
        if (hit_s || expire_s) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Next values of outputs and datapath; pulses default low, the rest hold.
  always_comb begin
    last_s        = last_r;
    lat_id_s      = lat_id_r;
    timer_s       = timer_r;
    req_ack_s     = 2'b00;
    res_valid_s   = 1'b0;
    res_id_s      = res_id_r;
    res_dout_s    = res_dout_r;
    res_timeout_s = res_timeout_r;
    eng_start_s   = 1'b0;
    eng_din_s     = eng_din_r;
    eng_iter_s    = eng_iter_r;
    case (state_r)
      IDLE: begin
        if (take_s) begin
          req_ack_s  = ack_onehot(grant_id_s);
          lat_id_s   = grant_id_s;
          eng_din_s  = grant_id_s ? req_din1 : req_din0;
          eng_iter_s = grant_id_s ? eff_iter(req_iter1) : eff_iter(req_iter0);
        end else begin
          req_ack_s = 2'b00;
        end
      end
      ISSUE: begin
        eng_start_s = 1'b1;
        timer_s     = {TMR_W{1'b0}};
      end
      WAIT: begin
        if (hit_s) begin
          res_valid_s   = 1'b1;
          res_id_s      = lat_id_r;
          res_dout_s    = eng_dout;
          res_timeout_s = 1'b0;
        end else if (expire_s) begin
          res_valid_s   = 1'b1;
          res_id_s      = lat_id_r;
          res_dout_s    = 16'd0;
          res_timeout_s = 1'b1;
        end else begin
          timer_s = timer_r + TMR_ONE;
        end
      end
      DONE: begin
        last_s = lat_id_r;
      end
      default: begin
        last_s = last_r;
      end
    endcase
  end

  // Output and datapath registers; reset clears everything and prefers requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r        <= 1'b1;
      lat_id_r      <= 1'b0;
      timer_r       <= {TMR_W{1'b0}};
      req_ack_r     <= 2'b00;
      res_valid_r   <= 1'b0;
      res_id_r      <= 1'b0;
      res_dout_r    <= 16'd0;
      res_timeout_r <= 1'b0;
      eng_start_r   <= 1'b0;
      eng_din_r     <= 32'd0;
      eng_iter_r    <= 5'd0;
    end else begin
      last_r        <= last_s;
      lat_id_r      <= lat_id_s;
      timer_r       <= timer_s;
      req_ack_r     <= req_ack_s;
      res_valid_r   <= res_valid_s;
      res_id_r      <= res_id_s;
      res_dout_r    <= res_dout_s;
      res_timeout_r <= res_timeout_s;
      eng_start_r   <= eng_start_s;
      eng_din_r     <= eng_din_s;
      eng_iter_r    <= eng_iter_s;
    end
  end

  assign req_ack     = req_ack_r;
  assign res_valid   = res_valid_r;
  assign res_id      = res_id_r;
  assign res_dout    = res_dout_r;
  assign res_timeout = res_timeout_r;
  assign eng_start   = eng_start_r;
  assign eng_vldin   = eng_start_r;
  assign eng_din     = eng_din_r;
  assign eng_iter    = eng_iter_r;

endmodule

// File: doc/sqrt_arbiter.md
SQRT_ARBITER -- requirements
Module: sqrt_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: max cycles in WAIT before abort.
REQ-002 SHALL have parameter DEFAULT_ITER, default 16: iteration count substituted when a request carries iter=0.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request; bit i = requester i.
- req_din0, req_din1  in  32  operand of requester 0 / 1.
- req_iter0, req_iter1  in  5  iteration count of requester 0 / 1.
- req_ack  out  2  one-cycle acceptance pulse, one-hot.
- res_valid  out  1  one-cycle result pulse.
- res_id  out  1  requester owning the result.
- res_dout  out  16  square-root result.
- res_timeout  out  1  result aborted by watchdog; valid with res_valid.
- eng_start, eng_vldin  out  1  engine start / input-valid strobes.
- eng_din  out  32  engine operand.
- eng_iter  out  5  engine iteration count.
- eng_dout  in  16  engine result.
- eng_ready  in  1  engine result pulse; eng_dout valid that cycle.
- eng_busy  in  1  engine computing.

Function
REQ-004 SHALL share one sqrt engine between two requesters, one operation in flight.
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-006 IDLE: if any req_valid bit high and eng_busy low, SHALL select a requester, pulse its req_ack, latch its din, iter and id, and enter ISSUE; otherwise SHALL stay in IDLE.
REQ-007 Selection SHALL be round-robin. The requester not granted last wins when both are valid. After reset, requester 0 is preferred.
REQ-008 Requester SHALL hold req_valid and data stable until req_ack. Deasserting before ack withdraws the request without side effects.
REQ-009 ISSUE: SHALL assert eng_start and eng_vldin for exactly one cycle with latched eng_din and eng_iter, clear the timer, and enter WAIT.
REQ-010 eng_iter SHALL equal the latched iter, or DEFAULT_ITER[4:0] when latched iter=0.
REQ-011 eng_din and eng_iter SHALL hold the latched values from ISSUE until leaving WAIT.
REQ-012 WAIT: the timer SHALL increment each cycle.
- On eng_ready: capture eng_dout and enter DONE with timeout=0.
- When the timer reaches TIMEOUT_CYC without eng_ready: enter DONE with res_dout=0 and timeout=1.
REQ-013 eng_ready and timer expiry in the same cycle SHALL resolve as eng_ready (no timeout).
REQ-014 eng_ready outside WAIT SHALL be ignored.
REQ-015 DONE: SHALL pulse res_valid for one cycle with res_id, res_dout and res_timeout, update the round-robin pointer, and return to IDLE.
REQ-016 res_id, res_dout and res_timeout SHALL hold their values until the next res_valid.
REQ-017 Minimum latency SHALL be: req_valid sampled in IDLE at edge N, req_ack high in cycle N+1, eng_start in cycle N+2, result reported in the cycle after eng_ready.
REQ-018 A new grant SHALL not occur before the cycle after res_valid.
REQ-019 Back-to-back requests from both requesters SHALL alternate.

Reset
REQ-020 rst high SHALL immediately force: state IDLE, RR pointer preferring 0, timer 0, and all outputs 0 (req_ack, res_valid, res_id, res_dout, res_timeout, eng_start, eng_vldin, eng_din, eng_iter).
REQ-021 Reset mid-operation SHALL abandon the in-flight request with no res_valid issued for it.

Verification
REQ-022 Bench SHALL cover: single request 0, din=144, iter=16, engine returns 12 after 20 cycles -> one req_ack[0], one eng_start, then res_valid with id=0, dout=12, timeout=0.
REQ-023 Bench SHALL cover: both requesters valid continuously, din0=100, din1=81 -> grants alternate 0,1,0,1; results 10 then 9 with matching ids.
REQ-024 Bench SHALL cover: request with iter=0 -> eng_iter=16 during ISSUE/WAIT.
REQ-025 Bench SHALL cover: engine never pulses eng_ready, TIMEOUT_CYC=255 -> res_valid with timeout=1, dout=0; arbiter then accepts the next request.
REQ-026 Bench SHALL cover: eng_busy high in IDLE with req_valid=01 -> no req_ack until eng_busy low; eng_ready in the same cycle as timer expiry -> timeout=0 and captured dout.
REQ-027 Bench SHALL cover: rst asserted in WAIT -> all outputs 0 immediately; no res_valid for the aborted request; a fresh request after release completes normally.
